led_pattern_engine: RTL

Parametrised LED pattern generator driving the board LED bar. It supersedes the fixed single-dot right-rotator with a configurable bar width, an internal step prescaler, and six display modes selected at run time: off, rotate right, rotate left, bounce, fill, and blink. It also emits step and wrap strobes so the top level can synchronise other effects to the pattern. It sits between the top-level mode/speed registers and the `led` pins.

---
 rtl/led_pkg.sv | 17 +
 rtl/led_pattern_engine_if.sv | 19 +
 rtl/led_prescaler.sv | 29 ++
 rtl/led_pattern_engine.sv | 126 ++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED pattern engine.
//   led_mode_t : run-time display mode encodings (6/7 reserved, act as OFF)
//   MODE_W     : width of the mode select field
package led_pkg;
  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 3'd0,
    MODE_ROT_R  = 3'd1,
    MODE_ROT_L  = 3'd2,
    MODE_BOUNCE = 3'd3,
    MODE_FILL   = 3'd4,
    MODE_BLINK  = 3'd5,
    MODE_RSV6   = 3'd6,
    MODE_RSV7   = 3'd7
  } led_mode_t;
endpackage

// File: rtl/led_pattern_engine_if.sv
// Control/status bundle between the mode/speed registers and the engine.
//   en, mode, period       : driven by the controller (master)
//   led, step_pulse, wrap  : driven by the engine (slave)
interface led_pattern_engine_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 27
);
  import led_pkg::*;

  logic                  en;
  logic [MODE_W-1:0]     mode;
  logic [CNT_W-1:0]      period;
  logic [WIDTH-1:0]      led;
  logic                  step_pulse;
  logic                  wrap;

  modport master (output en, mode, period, input led, step_pulse, wrap);
  modport slave  (input en, mode, period, output led, step_pulse, wrap);
endinterface

// File: rtl/led_prescaler.sv
// Step prescaler: counts enabled cycles and strobes tick every period+1 of them.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable (count holds when low)
//   clr        : synchronous clear; suppresses tick
//   period     : terminal count; compare is >= so a lowered period fires at once
//   tick       : step strobe for the current cycle (from registered count)
module led_prescaler #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;

  assign tick = en && !clr && (cnt >= period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (en) begin
      if (cnt >= period) cnt <= '0;
      else               cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/led_pattern_engine.sv
// LED bar pattern generator with run-time mode select.
//   clk, rst_n : clock, async active-low reset
//   bus (slave): en/mode/period in; led/step_pulse/wrap out (all registered)
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_pattern_engine_if.slave   bus
);
  localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = '1;

  led_mode_t        mode_q, mode_d;
  logic [WIDTH-1:0] led_q, led_nx, seed;
  logic             dir_q, dir_nx;   // BOUNCE: 0 = moving toward LSB
  logic             step_q, wrap_q, wrap_nx;
  logic             mode_chg, active, tick;

  assign mode_d   = led_mode_t'(bus.mode);
  assign mode_chg = (mode_d != mode_q);

  always_comb begin
    active = 1'b0;
    case (mode_q)
      MODE_ROT_R, MODE_ROT_L, MODE_BOUNCE, MODE_FILL, MODE_BLINK: active = 1'b1;
      default: active = 1'b0;
    endcase
  end

  // Hold the prescaler clear across a mode change so the new mode starts
  // a full period from the load edge; idle modes keep it parked at 0.
  led_prescaler #(.CNT_W(CNT_W)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (bus.en),
    .clr    (mode_chg || !active),
    .period (bus.period),
    .tick   (tick)
  );

  always_comb begin
    seed = '0;
    case (mode_d)
      MODE_ROT_R, MODE_BOUNCE: seed = MSB;
      MODE_ROT_L:              seed = LSB;
      MODE_BLINK:              seed = ONES;
      default:                 seed = '0;
    endcase
  end

  always_comb begin
    led_nx  = '0;
    dir_nx  = dir_q;
    wrap_nx = 1'b0;
    case (mode_q)
      MODE_ROT_R: begin
        led_nx  = {led_q[0], led_q[WIDTH-1:1]};
        wrap_nx = led_q[0];
      end
      MODE_ROT_L: begin
        led_nx  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        wrap_nx = led_q[WIDTH-1];
      end
      MODE_BOUNCE: begin
        // Turn around on the step that lands on an endpoint so each end is
        // shown exactly once per pass.
        if (!dir_q) begin
          led_nx = led_q >> 1;
          if (led_q[1]) dir_nx = 1'b1;
        end else begin
          led_nx = led_q << 1;
          if (led_q[WIDTH-2]) begin
            dir_nx  = 1'b0;
            wrap_nx = 1'b1;
          end
        end
      end
      MODE_FILL: begin
        if (led_q == ONES) begin
          led_nx  = '0;
          wrap_nx = 1'b1;
        end else begin
          led_nx = {1'b1, led_q[WIDTH-1:1]};
        end
      end
      MODE_BLINK: begin
        led_nx  = (led_q == '0) ? ONES : '0;
        wrap_nx = (led_q == '0);
      end
      default: led_nx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
      led_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (mode_chg) begin
      mode_q <= mode_d;
      led_q  <= seed;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (tick) begin
      led_q  <= led_nx;
      dir_q  <= dir_nx;
      step_q <= 1'b1;
      wrap_q <= wrap_nx;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end
  end

  assign bus.led        = led_q;
  assign bus.step_pulse = step_q;
  assign bus.wrap       = wrap_q;
endmodule
